// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared constants and the state encoding for the oversampled UART receiver.
//   No ports. Imported by uart_rx_oversampled.
package uart_pkg;

  localparam int UART_DBIT    = 8;
  localparam int UART_OS_RATE = 16;
  localparam int UART_SB_TICK = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

endpackage

// File: rtl/uart_rx_oversampled_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset; both flops load RESET_VAL
//   d        in  asynchronous input
//   q        out synchronized output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   UART receiver driven by an OS_RATE-times oversampling tick. Recovers
//   start / DBIT data (LSB first) / [parity] / stop frames and presents each
//   byte with a one-cycle done strobe.
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   s_tick        in   oversample tick, one-cycle pulse
//   rx            in   asynchronous serial line, idle high
//   dout          out  last received word, held until the next frame completes
//   rx_done_tick  out  one-cycle strobe, dout valid
//   frame_err     out  pulsed with rx_done_tick when the stop sample was 0
//   parity_err    out  (UART_RX_PARITY_EN only) pulsed with rx_done_tick on
//                      even-parity mismatch
//   busy          out  high whenever the FSM is not in IDLE
// Build option: define UART_RX_PARITY_EN to add the even-parity bit.
//
// state  | meaning
// IDLE   | line idle, waiting for a high-to-low edge on rx_s
// START  | counting to mid start bit, rejects glitches
// DATA   | sampling DBIT data bits at mid-bit, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | waiting out the stop period, then strobing the result
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int OS_RATE = UART_OS_RATE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            busy
);

  localparam int S_W = $clog2((OS_RATE > SB_TICK) ? OS_RATE : SB_TICK);
  localparam int N_W = $clog2(DBIT);

  localparam logic [S_W-1:0] S_MID  = S_W'(OS_RATE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OS_RATE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);
  localparam logic [S_W-1:0] S_ONE  = S_W'(1);
  localparam logic [N_W-1:0] N_ONE  = N_W'(1);

  state_t          state;
  logic [S_W-1:0]  s_cnt;
  logic [N_W-1:0]  n_cnt;
  logic [DBIT-1:0] b_reg;
  logic            rx_s;
  logic            rx_prev;
`ifdef UART_RX_PARITY_EN
  logic            p_err;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b_reg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      rx_prev      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      p_err        <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
`endif
      // Edge detect so that a line held low (break) cannot retrigger a frame.
      rx_prev <= rx_s;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            s_cnt <= '0;
            state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_cnt == S_MID) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                s_cnt <= '0;
                n_cnt <= '0;
                state <= DATA;
              end
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_cnt == S_BIT) begin
              b_reg <= {rx_s, b_reg[DBIT-1:1]};
              s_cnt <= '0;
              if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n_cnt <= n_cnt + N_ONE;
              end
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s_cnt == S_BIT) begin
              p_err <= (rx_s != (^b_reg));
              s_cnt <= '0;
              state <= STOP;
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s_cnt == S_STOP) begin
              dout         <= b_reg;
              rx_done_tick <= 1'b1;
              frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err   <= p_err;
`endif
              state        <= IDLE;
            end else begin
              s_cnt <= s_cnt + S_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled
//   Directed bench: s_tick every 4th clk, OS_RATE=16, so one bit = 64 clk.
module tb_uart_rx_oversampled;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       reset_n;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip;
  logic       last_perr;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  logic [7:0] cap_dout[$];
  logic       cap_fe[$];
  logic       busy_at_done;
  logic       busy_seen;
  int         tick_cnt = 0;

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .OS_RATE(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt == 3) ? 0 : tick_cnt + 1;
      s_tick = (tick_cnt == 3);
    end
  end

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (rx_done_tick) begin
      n_done++;
      cap_dout.push_back(dout);
      cap_fe.push_back(frame_err);
      busy_at_done = busy;
`ifdef UART_RX_PARITY_EN
      last_perr = parity_err;
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * BIT_CLK) @(negedge clk);
  endtask

  int base;

  initial begin
    rx      = 1'b1;
    reset_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flip  = 1'b0;
    last_perr = 1'b0;
`endif
    busy_seen    = 1'b0;
    busy_at_done = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_done", rx_done_tick, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    idle(2);

    // T1: 0x55
    base = n_done;
    busy_seen = 1'b0;
    send_frame(8'h55, 1'b1);
    idle(1);
    check("t1_strobes", n_done - base, 1);
    check("t1_dout", dout, 8'h55);
    check("t1_ferr", cap_fe[cap_fe.size()-1], 1'b0);
    check("t1_busy_seen", busy_seen, 1'b1);
    check("t1_busy_at_done", busy_at_done, 1'b0);
`ifdef UART_RX_PARITY_EN
    check("t1_perr", last_perr, 1'b0);
`endif

    // T2: 20 clk glitch
    base = n_done;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("t2_busy_seen", busy_seen, 1'b1);
    check("t2_busy_after", busy, 1'b0);
    check("t2_strobes", n_done - base, 0);
    check("t2_dout", dout, 8'h55);

    // T3: 0xA3 with stop bit 0
    base = n_done;
    send_frame(8'hA3, 1'b0);
    idle(1);
    check("t3_strobes", n_done - base, 1);
    check("t3_dout", dout, 8'hA3);
    check("t3_ferr", cap_fe[cap_fe.size()-1], 1'b1);

    // T4: back-to-back 0x00 then 0xFF
    base = n_done;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(1);
    check("t4_strobes", n_done - base, 2);
    check("t4_first", cap_dout[cap_dout.size()-2], 8'h00);
    check("t4_second", cap_dout[cap_dout.size()-1], 8'hFF);
    check("t4_ferr1", cap_fe[cap_fe.size()-2], 1'b0);
    check("t4_ferr2", cap_fe[cap_fe.size()-1], 1'b0);

    // Break: line held low for 14 bits gives one dout=0 frame_err=1 frame
    base = n_done;
    rx = 1'b0;
    repeat (14 * BIT_CLK) @(negedge clk);
    check("brk_strobes", n_done - base, 1);
    check("brk_dout", dout, 8'h00);
    check("brk_ferr", cap_fe[cap_fe.size()-1], 1'b1);
    check("brk_idle_low", busy, 1'b0);
    idle(2);
    check("brk_no_retrigger", n_done - base, 1);

    // T5: reset during data bit 4 of 0x3C, then 0x81
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(logic'((8'h3C >> i) & 8'h01));
    rx = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rst_dout", dout, 8'h00);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", rx_done_tick, 1'b0);
    check("t5_rst_ferr", frame_err, 1'b0);
    reset_n = 1'b1;
    base = n_done;
    idle(6);
    send_frame(8'h81, 1'b1);
    idle(1);
    check("t5_strobes", n_done - base, 1);
    check("t5_dout", dout, 8'h81);
    check("t5_ferr", cap_fe[cap_fe.size()-1], 1'b0);

`ifdef UART_RX_PARITY_EN
    // T6: 0x07 has odd data weight, even parity bit must be 1
    par_flip = 1'b1;
    base = n_done;
    send_frame(8'h07, 1'b1);
    idle(1);
    check("t6_bad_strobes", n_done - base, 1);
    check("t6_bad_perr", last_perr, 1'b1);
    check("t6_bad_dout", dout, 8'h07);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    idle(1);
    check("t6_good_strobes", n_done - base, 2);
    check("t6_good_perr", last_perr, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
